// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared constants, beat type and filter state encoding for eth_pkt_filter
package eth_pkg;

   localparam logic [15:0] ETH_FTYPE_IP      = 16'h0800;
   localparam logic [7:0]  IP_PROTO_ICMP     = 8'h01;
   localparam logic [7:0]  ICMP_DEST_UNREACH = 8'h03;
   localparam logic [7:0]  ICMP_PORT_UNREACH = 8'h03;

   // Field positions: beat index within the frame, lane LSB within that beat.
   localparam int ETYPE_BEAT    = 1;
   localparam int ETYPE_HI_LSB  = 32;
   localparam int ETYPE_LO_LSB  = 40;
   localparam int PROTO_BEAT    = 2;
   localparam int PROTO_LSB     = 56;
   localparam int ICMP_BEAT     = 4;
   localparam int ICMP_TYPE_LSB = 16;
   localparam int ICMP_CODE_LSB = 24;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
   } axis_beat_t;

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_FLUSH,
      ST_PASS,
      ST_DROP
   } filt_state_e;

   function automatic logic icmp_port_unreach(input logic [63:0] beat);
      return (beat[ICMP_TYPE_LSB +: 8] == ICMP_DEST_UNREACH) &&
             (beat[ICMP_CODE_LSB +: 8] == ICMP_PORT_UNREACH);
   endfunction

endpackage

// File: rtl/eth_pkt_filter_if.sv
// rtl/eth_pkt_filter_if.sv - 64-bit stream bundle with master/slave views
interface eth_pkt_filter_if;

   logic        tvalid;
   logic        tready;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tlast;
   logic        tuser;

   modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);

endinterface

// File: rtl/eth_hdr_buf.sv
// rtl/eth_hdr_buf.sv - small circular buffer holding the header beats of one frame
module eth_hdr_buf
   import eth_pkg::*;
#(
   parameter int  DEPTH = 5,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  axis_beat_t       wr_beat,
   output axis_beat_t       rd_beat,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   axis_beat_t       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_beat = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the pointers/count decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_beat;
      end
   end

endmodule

// File: rtl/eth_pkt_filter.sv
// rtl/eth_pkt_filter.sv - holds the header beats of each TX frame and drops ICMP port-unreachable frames
module eth_pkt_filter
   import eth_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter int HDR_BEATS = 5
) (
   input  logic             clk156,
   input  logic             eth_rst,
   input  logic             drop_en,
   eth_pkt_filter_if.slave  s_axis,
   eth_pkt_filter_if.master m_axis,
   output logic [CNT_W-1:0] fwd_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int BCNT_W = $clog2(HDR_BEATS + 1);

   filt_state_e       state_q, state_d;
   logic              drop_en_q, drop_en_d;
   logic              etype_ok_q, etype_ok_d;
   logic              proto_ok_q, proto_ok_d;
   logic              complete_q, complete_d;
   logic [CNT_W-1:0]  fwd_cnt_q, drop_cnt_q;

   logic              buf_push, buf_pop, buf_clear;
   logic              buf_full, buf_empty;
   logic [BCNT_W-1:0] buf_count;
   axis_beat_t        s_beat, buf_rd, m_beat;
   logic              s_ready, s_acc, m_valid;
   logic              hdr_match, fwd_inc, drop_inc;

   assign s_beat    = {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tuser};
   assign hdr_match = etype_ok_q & proto_ok_q & icmp_port_unreach(s_axis.tdata);

   eth_hdr_buf #(
      .DEPTH (HDR_BEATS)
   ) u_hdr_buf (
      .clk     (clk156),
      .rst     (eth_rst),
      .push    (buf_push),
      .pop     (buf_pop),
      .clear   (buf_clear),
      .wr_beat (s_beat),
      .rd_beat (buf_rd),
      .full    (buf_full),
      .empty   (buf_empty),
      .count   (buf_count)
   );

   // In HOLD the buffer fill level doubles as the index of the incoming beat.
   always_comb begin
      state_d    = state_q;
      drop_en_d  = drop_en_q;
      etype_ok_d = etype_ok_q;
      proto_ok_d = proto_ok_q;
      complete_d = complete_q;
      s_ready    = 1'b0;
      s_acc      = 1'b0;
      m_valid    = 1'b0;
      m_beat     = '0;
      buf_push   = 1'b0;
      buf_pop    = 1'b0;
      buf_clear  = 1'b0;
      drop_inc   = 1'b0;
      case (state_q)
         ST_HOLD: begin
            s_ready = ~buf_full;
            s_acc   = s_axis.tvalid & s_ready;
            if (s_acc) begin
               buf_push = 1'b1;
               if (buf_count == '0) begin
                  drop_en_d = drop_en;
               end
               if (buf_count == BCNT_W'(ETYPE_BEAT)) begin
                  etype_ok_d = ({s_axis.tdata[ETYPE_HI_LSB +: 8],
                                 s_axis.tdata[ETYPE_LO_LSB +: 8]} == ETH_FTYPE_IP);
               end
               if (buf_count == BCNT_W'(PROTO_BEAT)) begin
                  proto_ok_d = (s_axis.tdata[PROTO_LSB +: 8] == IP_PROTO_ICMP);
               end
               if (buf_count == BCNT_W'(ICMP_BEAT)) begin
                  if (hdr_match && drop_en_q) begin
                     // A 5-beat frame ending on the decision beat is dropped whole here.
                     buf_push  = 1'b0;
                     buf_clear = 1'b1;
                     drop_inc  = s_axis.tlast;
                     state_d   = s_axis.tlast ? ST_HOLD : ST_DROP;
                  end else begin
                     complete_d = s_axis.tlast;
                     state_d    = ST_FLUSH;
                  end
               end else if (s_axis.tlast) begin
                  complete_d = 1'b1;
                  state_d    = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            m_valid = ~buf_empty;
            m_beat  = buf_rd;
            buf_pop = m_axis.tready;
            if (m_axis.tready && buf_count == BCNT_W'(1)) begin
               state_d = complete_q ? ST_HOLD : ST_PASS;
            end
         end
         ST_PASS: begin
            s_ready = m_axis.tready;
            m_valid = s_axis.tvalid;
            m_beat  = s_beat;
            if (s_axis.tvalid && m_axis.tready && s_axis.tlast) begin
               state_d = ST_HOLD;
            end
         end
         ST_DROP: begin
            s_ready = 1'b1;
            if (s_axis.tvalid && s_axis.tlast) begin
               drop_inc = 1'b1;
               state_d  = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase
   end

   assign fwd_inc = m_valid & m_axis.tready & m_beat.last;

   always_ff @(posedge clk156 or posedge eth_rst) begin
      if (eth_rst) begin
         state_q    <= ST_HOLD;
         drop_en_q  <= 1'b0;
         etype_ok_q <= 1'b0;
         proto_ok_q <= 1'b0;
         complete_q <= 1'b0;
         fwd_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         drop_en_q  <= drop_en_d;
         etype_ok_q <= etype_ok_d;
         proto_ok_q <= proto_ok_d;
         complete_q <= complete_d;
         if (fwd_inc) begin
            fwd_cnt_q <= fwd_cnt_q + 1'b1;
         end
         if (drop_inc) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
         end
      end
   end

   assign s_axis.tready = s_ready & ~eth_rst;
   assign m_axis.tvalid = m_valid;
   assign m_axis.tdata  = m_beat.data;
   assign m_axis.tkeep  = m_beat.keep;
   assign m_axis.tlast  = m_beat.last;
   assign m_axis.tuser  = m_beat.user;
   assign fwd_cnt       = fwd_cnt_q;
   assign drop_cnt      = drop_cnt_q;

endmodule

// File: doc/eth_pkt_filter.md
# eth_pkt_filter

Per-packet drop/forward filter on the 64-bit AXI-Stream TX path, directly downstream of the loopback encapsulation stage and upstream of the 10G MAC TX. Holds the first five beats of each frame, classifies the frame as ICMP port-unreachable or not, then drops it or forwards it unchanged. Exposes forwarded and dropped frame counters for the board debug path.

## Interface
Parameters:
- CNT_W, 32, width of both frame counters
- HDR_BEATS, 5, header beats held before the decision; fixed by the classifier, not to be overridden

Ports:
- clk156  in  1  156.25 MHz clock
- eth_rst  in  1  reset, asynchronous, active-high
- drop_en  in  1  1 = drop matching frames; sampled on beat 0 acceptance, held for that frame
- s_axis_tvalid/tready/tdata/tkeep/tlast/tuser  in/out/in/in/in/in  1/1/64/8/1/1  upstream stream
- m_axis_tvalid/tready/tdata/tkeep/tlast/tuser  out/in/out/out/out/out  1/1/64/8/1/1  downstream stream
- fwd_cnt  out  CNT_W  frames forwarded
- drop_cnt  out  CNT_W  frames dropped

## Operation
- Byte order is little-endian: byte n of a frame sits at beat n/8, lanes [8*(n%8)+7 : 8*(n%8)].
- Classification fields:
  - ethertype = {beat1[39:32], beat1[47:40]}
  - IP protocol = beat2[63:56]
  - ICMP type = beat4[23:16]
  - ICMP code = beat4[31:24]
- match = ethertype 16'h0800, protocol 8'h01, type 8'h03, code 8'h03.
- States:
  - HOLD: accept beats into the buffer; s_tready=1 while buffer holds fewer than 5 beats; m_tvalid=0.
    - Beat 4 accepted without tlast: match & drop_en_latched -> DROP; otherwise -> FLUSH.
    - tlast accepted on beats 0..4: frame is too short to match -> FLUSH, and that frame is marked complete.
  - FLUSH: s_tready=0; emit buffered beats in order, one per cycle when m_tready.
    - Last buffered beat taken and frame complete -> HOLD with the buffer emptied.
    - Otherwise -> PASS.
  - PASS: combinational cut-through: m_* = s_*, s_tready = m_tready. Handshake on a tlast beat -> HOLD.
  - DROP: s_tready=1; discard beats. Accepted tlast -> HOLD.
- tkeep and tuser pass through unmodified on forwarded beats. tuser on dropped frames is ignored.
- fwd_cnt increments when a tlast beat completes a handshake on m_axis.
- drop_cnt increments on the accepted tlast of a DROP frame, or on beat 4 when that beat is itself tlast.
- Both counters wrap modulo 2^CNT_W.

## Timing
- Reset values:
  - m_axis_tvalid 0; m_axis_tdata 0; m_axis_tkeep 0; m_axis_tlast 0; m_axis_tuser 0
  - fwd_cnt 0; drop_cnt 0; state HOLD, buffer empty
  - s_axis_tready is forced 0 while eth_rst is high.
- Latency: first output beat is valid in the cycle after the decision beat is accepted, i.e. 5 cycles after beat 0 with no stalls. PASS adds 0 cycles.
- m_axis_tvalid, once asserted in FLUSH, holds with stable data until m_tready.
- drop_en changes mid-frame have no effect on that frame.
- Reset mid-frame: all state is cleared, and the next accepted beat is treated as beat 0. No resynchronisation to frame boundaries is attempted.
- Back-to-back frames: the first beat of a new frame can be accepted in the cycle after HOLD is re-entered, never in the same cycle as the previous tlast.
- A decision beat accepted in the same cycle as tlast resolves as the complete frame it is; it is never split across states.

## Structure
- Shared package eth_pkg holds:
  - ETH_FTYPE_IP, IP_PROTO_ICMP, ICMP_DEST_UNREACH, ICMP_PORT_UNREACH
  - beat/lane index constants for ethertype, proto, type and code
  - the filter state encoding
- Sub-module eth_hdr_buf:
  - 5-entry buffer of 64+8+1+1 bits with write pointer, read pointer and count
  - ports: push, pop, clear, full, empty

## Test plan
- ICMP type 3 code 3 frame, 10 beats, drop_en=1 -> no m_axis beats, drop_cnt=1, fwd_cnt=0.
- Same frame with drop_en=0 -> all 10 beats out bit-exact with first output 5 cycles after beat 0, fwd_cnt=1.
- UDP frame to port 12345, 8 beats, drop_en=1 -> forwarded intact including tkeep=8'h0F on the last beat, fwd_cnt=1.
- 3-beat runt frame -> forwarded after tlast; tlast is on output beat 2.
- Random m_tready at 50% across 20 mixed frames -> output stream equals input minus matching frames; counters sum to 20.
- eth_rst pulsed during PASS beat 6 -> outputs zero and counters 0; the following clean frame is handled correctly.
